nv_nvdla_cdma_dc_fifo_arb: RTL and testbench
============================================

# nv_nvdla_cdma_dc_fifo_arb

Two-requester write arbiter and occupancy scheduler for the CDMA DC 128x6 FIFO. It shares the FIFO's single write port between two producers with round-robin fairness, per-requester quota limits and a total-depth credit. It tracks the source of every in-flight entry, so pops from the FIFO read side return credit to the correct requester. It sits directly in front of the FIFO write port in the CDMA DC path, on the same clock.

## Interface
- DW, 6, entry data width (matches FIFO data width)
- DEPTH, 128, FIFO depth; total credit limit
- CW, 8, counter width (holds 0..DEPTH)
- clk  input  1  core clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req0_valid / req1_valid  input  1  requester has an entry
- req0_data / req1_data  input  DW  requester entry
- req0_ready / req1_ready  output  1  entry accepted this cycle (valid && ready)
- cfg_quota0 / cfg_quota1  input  CW  max in-flight entries per requester; 0 = no per-requester limit
- fifo_wr_req  output  1  to FIFO wr_req
- fifo_wr_data  output  DW  to FIFO wr_data
- fifo_wr_ready  input  1  from FIFO wr_ready
- fifo_rd_pop  input  1  FIFO read handshake (rd_req && rd_ready), one entry leaves
- occ0 / occ1  output  CW  current in-flight count per requester
- occ_total  output  CW  occ0 + occ1
- err_underflow  output  1  sticky: fifo_rd_pop seen with occ_total == 0

## Operation
- Reset values: fifo_wr_req 0, fifo_wr_data 0, occ0/occ1/occ_total 0, err_underflow 0, round-robin pointer = requester 0 preferred, ring pointers 0. The FIFO is reset in the same cycle as this block; resetting mid-operation discards all in-flight accounting.
- Output slot: one register (fifo_wr_req/fifo_wr_data). The slot is "free" when !fifo_wr_req or (fifo_wr_req && fifo_wr_ready). When the FIFO is not ready, the slot holds its data stable until the FIFO accepts it.
- Eligibility of requester i: reqi_valid && (cfg_quotai == 0 || occi < cfg_quotai) && occ_total < DEPTH.
- Grant: only when the slot is free. With one eligible requester, it wins. With both eligible, the requester not granted last wins; the pointer updates only on a grant. At most one grant per cycle. reqi_ready = grant_i (combinational).
- On grant: the slot loads reqi_data, occi and occ_total increment, src_ring[wr_ptr] <= i, wr_ptr++ (mod DEPTH).
- On fifo_rd_pop with occ_total > 0: src = src_ring[rd_ptr], occ_src and occ_total decrement, rd_ptr++ (mod DEPTH).
- Simultaneous grant and pop:
  - Same requester: occi unchanged.
  - Different requesters: one increments, the other decrements.
  - occ_total is unchanged in both cases.
- Pop with occ_total == 0: counters and pointers unchanged; err_underflow set; cleared only by reset.
- Quota change while running: takes effect on the next eligibility evaluation. If occi already exceeds the new quota, requester i is blocked until it drains below the quota; no entries are dropped.
- Arithmetic: counters are CW-bit unsigned and never wrap. occ_total never exceeds DEPTH. Ring pointers are log2(DEPTH) bits and wrap from 127 to 0. src_ring is DEPTH x 1 flops with no reset requirement.

## Timing
- Accept to fifo_wr_req: 1 cycle (registered slot).
- Sustained throughput: 1 entry/cycle while fifo_wr_ready = 1.
- A pop's credit is visible in occ*/eligibility the cycle after fifo_rd_pop.
- req*_ready depends combinationally on req*_valid, the occ* registers, fifo_wr_req and fifo_wr_ready. There is no combinational path from fifo_rd_pop to the outputs.
- The slot is counted in occ_total, so slot + FIFO never exceed DEPTH and fifo_wr_ready should not drop due to fullness. Backpressure from a FIFO wr_limit override is still honored by holding the slot.

## Test plan
- Both valid continuously, quotas 0, fifo_wr_ready = 1, no pops → grants alternate 0,1,0,1…; after 128 grants occ_total = 128, occ0 = occ1 = 64, both readies stay 0.
- cfg_quota0 = 3, only req0 valid, no pops → exactly 3 accepts; then a pop at cycle T → req0_ready = 1 at T+1, occ0 returns to 3.
- Hold fifo_wr_ready = 0 for 5 cycles with the slot loaded with 0x2A → fifo_wr_req and fifo_wr_data stay at 0x2A, no further grants; release → data accepted, next grant in the same cycle.
- Interleave 200 grants across both requesters with random pops, checking src order against a model → occ0/occ1 always match the model, ring pointers wrap past 127 correctly, final counts are 0 after all pops.
- Simultaneous grant to req1 and pop of a req1 entry → occ1 and occ_total unchanged; pop of a req0 entry instead → occ0 − 1, occ1 + 1.
- fifo_rd_pop with occ_total = 0 → err_underflow = 1 next cycle and stays 1; assert reset mid-traffic → all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/nv_nvdla_cdma_dc_fifo_arb.sv
`default_nettype none
// ============================================================================
// Module   : nv_nvdla_cdma_dc_fifo_arb
// Purpose  : Round-robin write arbiter with per-requester quota and credit
//            tracking in front of the CDMA DC 128x6 FIFO.
// Revision : 1.0
// ============================================================================
module nv_nvdla_cdma_dc_fifo_arb #(
  parameter int DW    = 6,
  parameter int DEPTH = 128,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  input  logic [CW-1:0] cfg_quota0,
  input  logic [CW-1:0] cfg_quota1,
  output logic          fifo_wr_req,
  output logic [DW-1:0] fifo_wr_data,
  input  logic          fifo_wr_ready,
  input  logic          fifo_rd_pop,
  output logic [CW-1:0] occ0,
  output logic [CW-1:0] occ1,
  output logic [CW-1:0] occ_total,
  output logic          err_underflow
);

  localparam int AW = $clog2(DEPTH);

  logic          r_prefer1;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic          r_src_ring [DEPTH];
  logic [CW-1:0] r_occ0;
  logic [CW-1:0] r_occ1;
  logic [CW-1:0] r_occ_total;
  logic          r_wr_req;
  logic [DW-1:0] r_wr_data;
  logic          r_err;

  logic w_slot_free;
  logic w_room;
  logic w_elig0;
  logic w_elig1;
  logic w_grant0;
  logic w_grant1;
  logic w_grant;
  logic w_pop;
  logic w_pop_src;
  logic w_dec0;
  logic w_dec1;

  // The output slot is counted in occ_total, so the credit check covers it.
  assign w_slot_free = !r_wr_req || fifo_wr_ready;
  assign w_room      = r_occ_total < CW'(DEPTH);
  assign w_elig0     = req0_valid && (cfg_quota0 == '0 || r_occ0 < cfg_quota0) && w_room;
  assign w_elig1     = req1_valid && (cfg_quota1 == '0 || r_occ1 < cfg_quota1) && w_room;

  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (w_slot_free) begin
      if (w_elig0 && w_elig1) begin
        w_grant0 = !r_prefer1;
        w_grant1 = r_prefer1;
      end else begin
        w_grant0 = w_elig0;
        w_grant1 = w_elig1;
      end
    end
  end

  assign w_grant   = w_grant0 || w_grant1;
  assign w_pop     = fifo_rd_pop && (r_occ_total != '0);
  assign w_pop_src = r_src_ring[r_rd_ptr];
  assign w_dec0    = w_pop && !w_pop_src;
  assign w_dec1    = w_pop && w_pop_src;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prefer1   <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_occ0      <= '0;
      r_occ1      <= '0;
      r_occ_total <= '0;
      r_wr_req    <= 1'b0;
      r_wr_data   <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_grant) begin
        r_prefer1 <= w_grant0;
        r_wr_ptr  <= r_wr_ptr + AW'(1);
        r_wr_req  <= 1'b1;
        r_wr_data <= w_grant1 ? req1_data : req0_data;
      end else if (fifo_wr_ready) begin
        r_wr_req  <= 1'b0;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (fifo_rd_pop && !w_pop) begin
        r_err <= 1'b1;
      end
      r_occ0      <= r_occ0 + CW'(w_grant0) - CW'(w_dec0);
      r_occ1      <= r_occ1 + CW'(w_grant1) - CW'(w_dec1);
      r_occ_total <= r_occ_total + CW'(w_grant) - CW'(w_pop);
    end
  end

  // Source ring needs no reset: entries are only read behind the write pointer.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_src_ring[r_wr_ptr] <= w_grant1;
    end
  end

  assign req0_ready    = w_grant0;
  assign req1_ready    = w_grant1;
  assign fifo_wr_req   = r_wr_req;
  assign fifo_wr_data  = r_wr_data;
  assign occ0          = r_occ0;
  assign occ1          = r_occ1;
  assign occ_total     = r_occ_total;
  assign err_underflow = r_err;

endmodule
`default_nettype wire

// File: tb/tb_nv_nvdla_cdma_dc_fifo_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_nv_nvdla_cdma_dc_fifo_arb
// Purpose  : Directed self-checking bench for the CDMA DC FIFO write arbiter.
// Revision : 1.0
// ============================================================================
module tb_nv_nvdla_cdma_dc_fifo_arb;

  localparam int DW    = 6;
  localparam int DEPTH = 128;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic [CW-1:0] cfg_quota0, cfg_quota1;
  logic          fifo_wr_req;
  logic [DW-1:0] fifo_wr_data;
  logic          fifo_wr_ready;
  logic          fifo_rd_pop;
  logic [CW-1:0] occ0, occ1, occ_total;
  logic          err_underflow;

  int errors = 0;
  int checks = 0;

  nv_nvdla_cdma_dc_fifo_arb #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .req0_valid    (req0_valid),
    .req0_data     (req0_data),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_data     (req1_data),
    .req1_ready    (req1_ready),
    .cfg_quota0    (cfg_quota0),
    .cfg_quota1    (cfg_quota1),
    .fifo_wr_req   (fifo_wr_req),
    .fifo_wr_data  (fifo_wr_data),
    .fifo_wr_ready (fifo_wr_ready),
    .fifo_rd_pop   (fifo_rd_pop),
    .occ0          (occ0),
    .occ1          (occ1),
    .occ_total     (occ_total),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
    fifo_rd_pop = 1'b0;
    tick();
    reset       = 1'b0;
  endtask

  initial begin
    int accepts;
    int grants;
    int exp_g;
    int m0, m1;
    bit prefer1;
    bit pop;
    int q[$];
    int s;

    reset = 1'b1; req0_valid = 0; req1_valid = 0; req0_data = 0; req1_data = 0;
    cfg_quota0 = 0; cfg_quota1 = 0; fifo_wr_ready = 1; fifo_rd_pop = 0;
    tick(); tick();
    chk("rst_wr_req", fifo_wr_req, 0);
    chk("rst_wr_data", fifo_wr_data, 0);
    chk("rst_occ0", occ0, 0);
    chk("rst_occ1", occ1, 0);
    chk("rst_occ_total", occ_total, 0);
    chk("rst_err", err_underflow, 0);
    reset = 1'b0;

    // Both valid, no pops: strict alternation until the credit runs out.
    req0_valid = 1; req1_valid = 1; req0_data = 6'h11; req1_data = 6'h22;
    for (int i = 0; i < 128; i++) begin
      #1;
      chk("alt_ready0", req0_ready, (i % 2 == 0) ? 1 : 0);
      chk("alt_ready1", req1_ready, (i % 2 == 1) ? 1 : 0);
      tick();
      chk("alt_data", fifo_wr_data, (i % 2 == 0) ? 'h11 : 'h22);
    end
    #1;
    chk("full_ready0", req0_ready, 0);
    chk("full_ready1", req1_ready, 0);
    chk("full_total", occ_total, 128);
    chk("full_occ0", occ0, 64);
    chk("full_occ1", occ1, 64);

    // Quota of 3 on requester 0.
    do_reset();
    cfg_quota0 = 3; req0_valid = 1; req0_data = 6'h05;
    accepts = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (req0_ready) accepts++;
      tick();
    end
    chk("quota_accepts", accepts, 3);
    chk("quota_occ0", occ0, 3);
    fifo_rd_pop = 1;
    #1;
    chk("quota_pop_ready_same", req0_ready, 0);
    tick();
    fifo_rd_pop = 0;
    chk("quota_occ0_after_pop", occ0, 2);
    #1;
    chk("quota_ready_after_pop", req0_ready, 1);
    tick();
    chk("quota_occ0_refill", occ0, 3);
    #1;
    chk("quota_ready_blocked", req0_ready, 0);
    cfg_quota0 = 0;

    // Backpressure holds the slot stable.
    do_reset();
    fifo_wr_ready = 0; req0_valid = 1; req0_data = 6'h2A;
    #1;
    chk("bp_first_grant", req0_ready, 1);
    tick();
    req0_data = 6'h15;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_wr_req", fifo_wr_req, 1);
      chk("bp_wr_data", fifo_wr_data, 'h2A);
      chk("bp_ready", req0_ready, 0);
      tick();
    end
    fifo_wr_ready = 1;
    #1;
    chk("bp_release_ready", req0_ready, 1);
    tick();
    req0_valid = 0;
    chk("bp_next_data", fifo_wr_data, 'h15);
    chk("bp_next_req", fifo_wr_req, 1);
    chk("bp_occ0", occ0, 2);

    // Grant to req1 while popping a req1 entry.
    do_reset();
    req1_valid = 1; req1_data = 6'h03;
    tick();
    fifo_rd_pop = 1;
    tick();
    fifo_rd_pop = 0; req1_valid = 0;
    chk("same_occ1", occ1, 1);
    chk("same_total", occ_total, 1);

    // Grant to req1 while popping a req0 entry.
    do_reset();
    req0_valid = 1;
    tick();
    req0_valid = 0; req1_valid = 1; fifo_rd_pop = 1;
    tick();
    fifo_rd_pop = 0; req1_valid = 0;
    chk("cross_occ0", occ0, 0);
    chk("cross_occ1", occ1, 1);
    chk("cross_total", occ_total, 1);

    // 200 grants with random pops against a source-order model.
    do_reset();
    req0_valid = 1; req1_valid = 1;
    grants = 0; m0 = 0; m1 = 0; prefer1 = 0; q = {};
    for (int cyc = 0; cyc < 3000 && grants < 200; cyc++) begin
      exp_g = (m0 + m1 < DEPTH) ? (prefer1 ? 1 : 0) : -1;
      pop = (q.size() > 0) && ($urandom_range(1, 0) == 1);
      fifo_rd_pop = pop;
      #1;
      chk("rr_ready0", req0_ready, (exp_g == 0) ? 1 : 0);
      chk("rr_ready1", req1_ready, (exp_g == 1) ? 1 : 0);
      tick();
      if (pop) begin
        s = q.pop_front();
        if (s == 0) m0--; else m1--;
      end
      if (exp_g >= 0) begin
        q.push_back(exp_g);
        if (exp_g == 0) m0++; else m1++;
        prefer1 = (exp_g == 0);
        grants++;
      end
      chk("rr_occ0", occ0, m0);
      chk("rr_occ1", occ1, m1);
      chk("rr_total", occ_total, m0 + m1);
    end
    chk("rr_grant_budget", grants, 200);
    req0_valid = 0; req1_valid = 0;
    for (int cyc = 0; cyc < 300 && q.size() > 0; cyc++) begin
      fifo_rd_pop = 1;
      tick();
      s = q.pop_front();
      if (s == 0) m0--; else m1--;
      chk("drain_occ0", occ0, m0);
      chk("drain_occ1", occ1, m1);
    end
    fifo_rd_pop = 0;
    chk("drain_total", occ_total, 0);
    chk("drain_err", err_underflow, 0);

    // Underflow is sticky; reset mid-traffic clears everything.
    do_reset();
    fifo_rd_pop = 1;
    tick();
    fifo_rd_pop = 0;
    chk("uf_err", err_underflow, 1);
    chk("uf_total", occ_total, 0);
    tick(); tick();
    chk("uf_sticky", err_underflow, 1);
    req0_valid = 1; req1_valid = 1; req0_data = 6'h1F;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_total_before", occ_total, 5);
    reset = 1;
    tick();
    chk("mid_wr_req", fifo_wr_req, 0);
    chk("mid_wr_data", fifo_wr_data, 0);
    chk("mid_occ0", occ0, 0);
    chk("mid_occ1", occ1, 0);
    chk("mid_total", occ_total, 0);
    chk("mid_err", err_underflow, 0);
    reset = 0; req0_valid = 0; req1_valid = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
